// File: rtl/cpu_apb_master.sv
// CPU data-bus to APB bridge: decodes one slave per request, runs SETUP/ACCESS
// with wait states, and returns a one-cycle ready with error on unmapped/timeout.
module cpu_apb_master #(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                NUM_SLAVES   = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h1000_0000,
  parameter int                SLAVE_ADDR_W = 12,
  parameter int                TIMEOUT      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         transfer,
  input  logic                         busWe,
  input  logic [ADDR_W-1:0]            busAddr,
  input  logic [DATA_W-1:0]            busWData,
  input  logic [DATA_W/8-1:0]          Byte_Enable,
  output logic [DATA_W-1:0]            busRData,
  output logic                         ready,
  output logic                         error,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W/8-1:0]          PSTRB,
  output logic                         PWRITE,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY
);
  localparam int SW = DATA_W/8;
  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0]     strb_q, strb_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] req_idx;
  logic              mapped, sel_rdy;
  logic [DATA_W-1:0] sel_rdata;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    idx_d   = idx_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    // Full-width index so addresses far above the slave window never alias back in.
    req_idx   = (busAddr >> SLAVE_ADDR_W) - (BASE_ADDR >> SLAVE_ADDR_W);
    mapped    = (busAddr >= BASE_ADDR) && (req_idx < ADDR_W'(NUM_SLAVES));
    sel_rdy   = PREADY[idx_q];
    sel_rdata = PRDATA[idx_q*DATA_W +: DATA_W];
    case (state_q)
      IDLE: if (transfer) begin
        we_d    = busWe;
        addr_d  = busAddr;
        wdata_d = busWData;
        strb_d  = Byte_Enable;
        idx_d   = req_idx[IW-1:0];
        err_d   = !mapped;
        rdata_d = '0;
        cnt_d   = '0;
        state_d = mapped ? SETUP : RESP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (sel_rdy) begin
          if (!we_q) rdata_d = sel_rdata;
          state_d = RESP;
        end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registered state only; nothing passes through from transfer/PREADY.
  always_comb begin
    PSEL = '0;
    if (state_q == SETUP || state_q == ACCESS) PSEL[idx_q] = 1'b1;
  end

  assign PENABLE  = (state_q == ACCESS);
  assign PADDR    = addr_q;
  assign PWDATA   = wdata_q;
  assign PWRITE   = we_q;
  assign PSTRB    = we_q ? strb_q : '0;
  assign ready    = (state_q == RESP);
  assign error    = ready & err_q;
  assign busRData = (ready && !err_q) ? rdata_q : '0;
endmodule

// File: tb/tb_cpu_apb_master.sv
// Scoreboard bench for cpu_apb_master: behavioural APB slaves with
// programmable wait states, latency/select/strobe checks per request.
module tb_cpu_apb_master;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        transfer = 1'b0;
  logic        busWe = 1'b0;
  logic [31:0] busAddr = '0;
  logic [31:0] busWData = '0;
  logic [3:0]  Byte_Enable = '0;
  logic [31:0] busRData;
  logic        ready, error;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic        PWRITE, PENABLE;
  logic [3:0]  PSEL;
  logic [127:0] PRDATA;
  logic [3:0]  PREADY;

  cpu_apb_master dut (
    .clk(clk), .reset(reset), .transfer(transfer), .busWe(busWe),
    .busAddr(busAddr), .busWData(busWData), .Byte_Enable(Byte_Enable),
    .busRData(busRData), .ready(ready), .error(error),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 clk = ~clk;

  // Slave model: ready after slv_wait ACCESS cycles unless stuck.
  logic [31:0] mem [4];
  int          slv_wait = 0;
  bit          stuck = 1'b0;
  int          acc_cnt = 0;
  always @(posedge clk) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;
  for (genvar i = 0; i < 4; i++) begin : g_slv
    assign PREADY[i] = PSEL[i] & PENABLE & ~stuck & (acc_cnt >= slv_wait);
    assign PRDATA[i*32 +: 32] = mem[i];
  end

  typedef struct { logic err; logic [31:0] rd; } exp_t;
  exp_t sbq[$];
  int   total = 0, bad = 0, rdy_total = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ready) begin
      rdy_total++;
      if (sbq.size() == 0) chk("spurious_ready", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_err", error, e.err);
        chk("sb_rdata", busRData, e.rd);
      end
    end
  end

  task automatic do_req(input string tag, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int wt, input bit stk, input bit exp_err,
                        input logic [31:0] exp_rd, input int exp_lat, input int exp_en,
                        input logic [3:0] exp_sel, input bit poke);
    int n, selc, enc, r0;
    logic [3:0] selor, cstrb;
    logic [31:0] caddr, cwdata;
    logic cwr;
    bit done;
    n = 0; selc = 0; enc = 0; selor = '0; cstrb = '0; caddr = '0; cwdata = '0; cwr = 0;
    done = 0;
    slv_wait = wt; stuck = stk;
    @(negedge clk);
    r0 = rdy_total;
    transfer = 1; busWe = we; busAddr = addr; busWData = wdata; Byte_Enable = be;
    sbq.push_back('{exp_err, exp_rd});
    @(posedge clk);
    #1 transfer = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (poke && n == 2) begin transfer = 1; busAddr = 32'h1000_2000; end
      if (poke && n == 3) begin transfer = 0; busAddr = addr; end
      if (PSEL != 0) begin
        selc++; selor |= PSEL; cstrb = PSTRB; caddr = PADDR; cwdata = PWDATA; cwr = PWRITE;
      end
      if (PENABLE) enc++;
      if (ready) done = 1;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_en_cyc"}, enc, exp_en);
    chk({tag, "_sel_cyc"}, selc, (exp_sel != 0) ? exp_en + 1 : 0);
    chk({tag, "_psel"}, selor, exp_sel);
    chk({tag, "_psel_at_rdy"}, PSEL, 0);
    if (exp_sel != 0) begin
      chk({tag, "_paddr"}, caddr, addr);
      chk({tag, "_pwrite"}, cwr, we);
      chk({tag, "_pstrb"}, cstrb, we ? be : 4'h0);
      if (we) chk({tag, "_pwdata"}, cwdata, wdata);
    end
    if (poke) begin
      repeat (3) @(negedge clk);
      chk({tag, "_one_ready"}, rdy_total - r0, 1);
    end
  endtask

  initial begin
    mem[0] = 32'hA5A5_0000; mem[1] = 32'h0BAD_F00D;
    mem[2] = 32'hCAFE_0002; mem[3] = 32'h1234_5678;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_error", error, 0);
    chk("rst_rdata", busRData, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pstrb", PSTRB, 0);
    chk("rst_pwrite", PWRITE, 0);
    reset = 1;

    do_req("wr0", 1, 32'h1000_1004, 32'hDEAD_BEEF, 4'b0011, 0, 0, 0, 32'h0, 3, 1, 4'b0010, 0);
    do_req("rd_w2", 0, 32'h1000_3000, 32'h0, 4'hF, 2, 0, 0, 32'h1234_5678, 5, 3, 4'b1000, 0);
    do_req("um_hi", 0, 32'h1000_4000, 32'h0, 4'hF, 0, 0, 1, 32'h0, 1, 0, 4'b0000, 0);
    do_req("um_lo", 1, 32'h0FFF_FFFC, 32'h1111_2222, 4'hF, 0, 0, 1, 32'h0, 1, 0, 4'b0000, 0);
    do_req("rd2", 0, 32'h1000_2FFC, 32'h0, 4'hF, 0, 0, 0, 32'hCAFE_0002, 3, 1, 4'b0100, 0);
    do_req("wr3_w1", 1, 32'h1000_3010, 32'h5555_AAAA, 4'b1100, 1, 0, 0, 32'h0, 4, 2, 4'b1000, 0);
    do_req("tmo", 0, 32'h1000_0008, 32'h0, 4'hF, 0, 1, 1, 32'h0, 18, 16, 4'b0001, 0);
    do_req("poke", 0, 32'h1000_1000, 32'h0, 4'hF, 3, 0, 0, 32'h0BAD_F00D, 6, 4, 4'b0010, 1);

    // Reset while in ACCESS: outputs must drop without a clock edge.
    slv_wait = 0; stuck = 1;
    @(negedge clk);
    transfer = 1; busWe = 0; busAddr = 32'h1000_0000;
    @(posedge clk);
    #1 transfer = 0;
    begin
      int k;
      k = 0;
      while (!PENABLE && k < 10) begin @(negedge clk); k++; end
      chk("mid_reach_access", PENABLE, 1);
    end
    #2;
    sbq.delete();
    reset = 0;
    #1;
    chk("mid_psel", PSEL, 0);
    chk("mid_penable", PENABLE, 0);
    chk("mid_ready", ready, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    do_req("post_rst", 0, 32'h1000_0000, 32'h0, 4'hF, 0, 0, 0, 32'hA5A5_0000, 3, 1, 4'b0001, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
